// File: rtl/instr_mem_loader_fetch_pkg.sv
// Shared constants, state type, response record and lane-mapping helper
// for the instruction memory loader/fetch block.
package imem_pkg;
  localparam int INSTR_W        = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int MAX_FETCH_W    = 4;
  localparam int MAX_PC_W       = 32;

  typedef enum logic {LOAD, RUN} imem_state_t;

  // Widest-case view of one fetch response; narrower configurations use the low bits.
  typedef struct packed {
    logic                           valid;
    logic [MAX_FETCH_W*INSTR_W-1:0] instr;
    logic [MAX_FETCH_W-1:0]         mask;
    logic                           err;
    logic [MAX_PC_W-1:0]            pc;
  } fetch_rsp_t;

  // Bit offset of load lane inside a word; big-endian puts lane 0 at the top byte.
  function automatic logic [4:0] lane_shift(input logic [1:0] lane, input logic little_endian);
    return little_endian ? {lane, 3'b000} : {~lane, 3'b000};
  endfunction
endpackage

// File: rtl/instr_mem_loader_fetch_if.sv
// Load-port and fetch-port signal bundle; master drives requests and bytes,
// slave is the instruction memory.
interface instr_mem_loader_fetch_if #(
  parameter int DEPTH_WORDS = 256,
  parameter int FETCH_WIDTH = 2
);
  import imem_pkg::*;

  localparam int PC_W  = $clog2(DEPTH_WORDS*BYTES_PER_WORD);
  localparam int CNT_W = $clog2(DEPTH_WORDS+1);

  logic                           load_valid;
  logic                           load_ready;
  logic [7:0]                     load_byte;
  logic                           load_last;
  logic [CNT_W-1:0]               loaded_words;
  logic                           mem_ready;
  logic                           fetch_req_valid;
  logic                           fetch_req_ready;
  logic [PC_W-1:0]                fetch_pc;
  logic                           flush;
  logic                           fetch_rsp_valid;
  logic                           fetch_rsp_ready;
  logic [INSTR_W*FETCH_WIDTH-1:0] fetch_rsp_instr;
  logic [FETCH_WIDTH-1:0]         fetch_rsp_mask;
  logic                           fetch_rsp_err;
  logic [PC_W-1:0]                fetch_rsp_pc;

  modport master (
    output load_valid, load_byte, load_last,
    output fetch_req_valid, fetch_pc, flush, fetch_rsp_ready,
    input  load_ready, loaded_words, mem_ready, fetch_req_ready,
    input  fetch_rsp_valid, fetch_rsp_instr, fetch_rsp_mask, fetch_rsp_err, fetch_rsp_pc
  );

  modport slave (
    input  load_valid, load_byte, load_last,
    input  fetch_req_valid, fetch_pc, flush, fetch_rsp_ready,
    output load_ready, loaded_words, mem_ready, fetch_req_ready,
    output fetch_rsp_valid, fetch_rsp_instr, fetch_rsp_mask, fetch_rsp_err, fetch_rsp_pc
  );
endinterface

// File: rtl/instr_mem_loader_fetch_byte_packer.sv
// Assembles the serial load stream into 32-bit words: byte counter, endian
// lane steering and zero-padding of a short final word.
module imem_byte_packer
  import imem_pkg::*;
#(
  parameter  int DEPTH_WORDS   = 256,
  parameter  int LITTLE_ENDIAN = 1,
  localparam int PC_W          = $clog2(DEPTH_WORDS*BYTES_PER_WORD),
  localparam int AW            = PC_W - 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_take,
  input  logic [7:0]         i_byte,
  input  logic               i_last,
  output logic               o_wr_en,
  output logic [AW-1:0]      o_wr_addr,
  output logic [INSTR_W-1:0] o_wr_data,
  output logic               o_done
);
  logic [PC_W-1:0]    r_byte_cnt;
  logic [INSTR_W-1:0] r_word;
  logic [1:0]         w_lane;
  logic               w_final;
  logic [INSTR_W-1:0] w_word;

  assign w_lane  = r_byte_cnt[1:0];
  assign w_final = (r_byte_cnt == PC_W'(DEPTH_WORDS*BYTES_PER_WORD-1));
  // r_word is cleared after every write, so lanes not yet filled read as 0x00.
  assign w_word  = r_word | (INSTR_W'(i_byte) << lane_shift(w_lane, LITTLE_ENDIAN != 0));

  assign o_done    = i_take && (i_last || w_final);
  assign o_wr_en   = i_take && ((w_lane == 2'd3) || i_last || w_final);
  assign o_wr_addr = r_byte_cnt[PC_W-1:2];
  assign o_wr_data = w_word;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (i_take) begin
      if (!w_final) r_byte_cnt <= r_byte_cnt + PC_W'(1);
      r_word <= o_wr_en ? '0 : w_word;
    end
  end
endmodule

// File: rtl/instr_mem_loader_fetch.sv
// Instruction memory: byte-serial boot load, then multi-slot fetch with a
// one-cycle registered response, backpressure and flush.
module instr_mem_loader_fetch
  import imem_pkg::*;
#(
  parameter  int DEPTH_WORDS   = 256,
  parameter  int FETCH_WIDTH   = 2,
  parameter  int LITTLE_ENDIAN = 1,
  localparam int PC_W          = $clog2(DEPTH_WORDS*BYTES_PER_WORD),
  localparam int CNT_W         = $clog2(DEPTH_WORDS+1),
  localparam int AW            = PC_W - 2
) (
  input logic                     clk,
  input logic                     reset_n,
  instr_mem_loader_fetch_if.slave bus
);
  imem_state_t                    r_state;
  logic [CNT_W-1:0]               r_loaded_words;
  logic [INSTR_W-1:0]             r_mem [DEPTH_WORDS];
  logic                           r_rsp_valid;
  logic [INSTR_W*FETCH_WIDTH-1:0] r_rsp_instr;
  logic [FETCH_WIDTH-1:0]         r_rsp_mask;
  logic                           r_rsp_err;
  logic [PC_W-1:0]                r_rsp_pc;

  logic                           w_take;
  logic                           w_wr_en;
  logic                           w_done;
  logic [AW-1:0]                  w_wr_addr;
  logic [INSTR_W-1:0]             w_wr_data;
  logic                           w_req_ready;
  logic                           w_accept;
  logic                           w_misaligned;
  logic [CNT_W-1:0]               w_slot_word [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0]         w_slot_mask;

  assign w_take = bus.load_valid && (r_state == LOAD);

  imem_byte_packer #(
    .DEPTH_WORDS   (DEPTH_WORDS),
    .LITTLE_ENDIAN (LITTLE_ENDIAN)
  ) u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_take    (w_take),
    .i_byte    (bus.load_byte),
    .i_last    (bus.load_last),
    .o_wr_en   (w_wr_en),
    .o_wr_addr (w_wr_addr),
    .o_wr_data (w_wr_data),
    .o_done    (w_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= LOAD;
      r_loaded_words <= '0;
    end else begin
      if (w_wr_en) r_loaded_words <= r_loaded_words + CNT_W'(1);
      if (w_done)  r_state        <= RUN;
    end
  end

  // No reset on the array: slots past loaded_words are masked off instead.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
  end

  assign w_req_ready  = (r_state == RUN) && !bus.flush && (!r_rsp_valid || bus.fetch_rsp_ready);
  assign w_accept     = bus.fetch_req_valid && w_req_ready;
  assign w_misaligned = (bus.fetch_pc[1:0] != 2'b00);

  // Slot word index is one bit wider than the array address so it never wraps.
  always_comb begin
    w_slot_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_slot_word[i] = CNT_W'(bus.fetch_pc[PC_W-1:2]) + CNT_W'(i);
      w_slot_mask[i] = !w_misaligned && (w_slot_word[i] < r_loaded_words)
                       && (w_slot_word[i] < CNT_W'(DEPTH_WORDS));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_instr <= '0;
      r_rsp_mask  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_pc    <= '0;
    end else if (bus.flush) begin
      r_rsp_valid <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_mask  <= w_slot_mask;
      r_rsp_err   <= w_misaligned;
      r_rsp_pc    <= bus.fetch_pc;
      for (int i = 0; i < FETCH_WIDTH; i++)
        r_rsp_instr[i*INSTR_W +: INSTR_W] <= w_slot_mask[i] ? r_mem[w_slot_word[i][AW-1:0]] : '0;
    end else if (bus.fetch_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.load_ready      = (r_state == LOAD);
  assign bus.mem_ready       = (r_state == RUN);
  assign bus.loaded_words    = r_loaded_words;
  assign bus.fetch_req_ready = w_req_ready;
  assign bus.fetch_rsp_valid = r_rsp_valid;
  assign bus.fetch_rsp_instr = r_rsp_instr;
  assign bus.fetch_rsp_mask  = r_rsp_mask;
  assign bus.fetch_rsp_err   = r_rsp_err;
  assign bus.fetch_rsp_pc    = r_rsp_pc;
endmodule

// File: tb/tb_instr_mem_loader_fetch.sv
// Bench for instr_mem_loader_fetch: instance A (256 words, 2 slots, little-endian)
// and instance B (4 words, 4 slots, big-endian), checked through a response scoreboard.
module tb_instr_mem_loader_fetch;
  import imem_pkg::*;

  logic clk = 1'b0;
  logic rst_na;
  logic rst_nb;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  instr_mem_loader_fetch_if #(.DEPTH_WORDS(256), .FETCH_WIDTH(2)) ifa ();
  instr_mem_loader_fetch_if #(.DEPTH_WORDS(4),   .FETCH_WIDTH(4)) ifb ();

  instr_mem_loader_fetch #(.DEPTH_WORDS(256), .FETCH_WIDTH(2), .LITTLE_ENDIAN(1)) u_dut_a (
    .clk(clk), .reset_n(rst_na), .bus(ifa)
  );
  instr_mem_loader_fetch #(.DEPTH_WORDS(4), .FETCH_WIDTH(4), .LITTLE_ENDIAN(0)) u_dut_b (
    .clk(clk), .reset_n(rst_nb), .bus(ifb)
  );

  logic [31:0] ma [256];
  int          la;
  logic [31:0] mb [4];
  int          lb;
  fetch_rsp_t  qa [$];
  fetch_rsp_t  qb [$];
  fetch_rsp_t  hold_e;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic fetch_rsp_t exp_a(input logic [31:0] pc);
    fetch_rsp_t r = '0;
    r.valid = 1'b1;
    r.pc    = pc;
    if (pc[1:0] != 2'b00) r.err = 1'b1;
    else
      for (int i = 0; i < 2; i++) begin
        int w;
        w = int'(pc >> 2) + i;
        if (w < la && w < 256) begin
          r.mask[i] = 1'b1;
          r.instr[32*i +: 32] = ma[w];
        end
      end
    return r;
  endfunction

  function automatic fetch_rsp_t exp_b(input logic [31:0] pc);
    fetch_rsp_t r = '0;
    r.valid = 1'b1;
    r.pc    = pc;
    if (pc[1:0] != 2'b00) r.err = 1'b1;
    else
      for (int i = 0; i < 4; i++) begin
        int w;
        w = int'(pc >> 2) + i;
        if (w < lb && w < 4) begin
          r.mask[i] = 1'b1;
          r.instr[32*i +: 32] = mb[w];
        end
      end
    return r;
  endfunction

  // Scoreboard A: retire (or drop on flush) the oldest entry, then record new acceptances.
  always @(negedge clk) begin
    fetch_rsp_t e;
    if (rst_na && ifa.fetch_rsp_valid && (ifa.flush || ifa.fetch_rsp_ready)) begin
      check_val("A.sb_has_entry", 128'(qa.size() != 0), 128'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        if (!ifa.flush) begin
          check_val("A.instr", 128'(ifa.fetch_rsp_instr), e.instr);
          check_val("A.mask",  128'(ifa.fetch_rsp_mask),  128'(e.mask));
          check_val("A.err",   128'(ifa.fetch_rsp_err),   128'(e.err));
          check_val("A.pc",    128'(ifa.fetch_rsp_pc),    128'(e.pc));
        end
      end
    end
    if (rst_na && ifa.fetch_req_valid && ifa.fetch_req_ready) qa.push_back(exp_a(32'(ifa.fetch_pc)));
  end

  always @(negedge clk) begin
    fetch_rsp_t e;
    if (rst_nb && ifb.fetch_rsp_valid && (ifb.flush || ifb.fetch_rsp_ready)) begin
      check_val("B.sb_has_entry", 128'(qb.size() != 0), 128'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        if (!ifb.flush) begin
          check_val("B.instr", ifb.fetch_rsp_instr,      e.instr);
          check_val("B.mask",  128'(ifb.fetch_rsp_mask), 128'(e.mask));
          check_val("B.err",   128'(ifb.fetch_rsp_err),  128'(e.err));
          check_val("B.pc",    128'(ifb.fetch_rsp_pc),   128'(e.pc));
        end
      end
    end
    if (rst_nb && ifb.fetch_req_valid && ifb.fetch_req_ready) qb.push_back(exp_b(32'(ifb.fetch_pc)));
  end

  task automatic a_idle();
    ifa.load_valid = 1'b0; ifa.load_byte = '0; ifa.load_last = 1'b0;
    ifa.fetch_req_valid = 1'b0; ifa.fetch_pc = '0; ifa.flush = 1'b0; ifa.fetch_rsp_ready = 1'b1;
  endtask

  task automatic b_idle();
    ifb.load_valid = 1'b0; ifb.load_byte = '0; ifb.load_last = 1'b0;
    ifb.fetch_req_valid = 1'b0; ifb.fetch_pc = '0; ifb.flush = 1'b0; ifb.fetch_rsp_ready = 1'b1;
  endtask

  task automatic a_reset();
    a_idle(); rst_na = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_na = 1'b1; qa.delete();
  endtask

  task automatic b_reset();
    b_idle(); rst_nb = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_nb = 1'b1; qb.delete();
  endtask

  task automatic a_byte(input logic [7:0] b, input logic last);
    ifa.load_valid = 1'b1; ifa.load_byte = b; ifa.load_last = last;
    @(posedge clk); #1;
    ifa.load_valid = 1'b0; ifa.load_last = 1'b0;
  endtask

  task automatic b_byte(input logic [7:0] b, input logic last);
    ifb.load_valid = 1'b1; ifb.load_byte = b; ifb.load_last = last;
    @(posedge clk); #1;
    ifb.load_valid = 1'b0; ifb.load_last = 1'b0;
  endtask

  task automatic a_fetch(input logic [31:0] pc);
    bit ok = 1'b0;
    ifa.fetch_req_valid = 1'b1; ifa.fetch_pc = pc[9:0];
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk); ok = ifa.fetch_req_ready;
      @(posedge clk); #1;
    end
    ifa.fetch_req_valid = 1'b0;
    check_val("A.accept", 128'(ok), 128'd1);
    if (ok) check_val("A.latency", 128'(ifa.fetch_rsp_valid), 128'd1);
  endtask

  task automatic b_fetch(input logic [31:0] pc);
    bit ok = 1'b0;
    ifb.fetch_req_valid = 1'b1; ifb.fetch_pc = pc[3:0];
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk); ok = ifb.fetch_req_ready;
      @(posedge clk); #1;
    end
    ifb.fetch_req_valid = 1'b0;
    check_val("B.accept", 128'(ok), 128'd1);
    if (ok) check_val("B.latency", 128'(ifb.fetch_rsp_valid), 128'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [8];
    logic [7:0] t2 [7];
    logic [7:0] t3 [12];
    t1 = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    t2 = '{8'h00, 8'h00, 8'h05, 8'h13, 8'h00, 8'h10, 8'h00};
    t3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    rst_na = 1'b0; rst_nb = 1'b0;
    a_idle(); b_idle();
    la = 0; lb = 0;

    a_reset();
    check_val("A.rst_load_ready", 128'(ifa.load_ready),      128'd1);
    check_val("A.rst_loaded",     128'(ifa.loaded_words),    128'd0);
    check_val("A.rst_mem_ready",  128'(ifa.mem_ready),       128'd0);
    check_val("A.rst_rsp_valid",  128'(ifa.fetch_rsp_valid), 128'd0);
    check_val("A.rst_req_ready",  128'(ifa.fetch_req_ready), 128'd0);
    check_val("A.rst_rsp_instr",  128'(ifa.fetch_rsp_instr), 128'd0);

    // Little-endian load of two words, then fetches
    for (int i = 0; i < 8; i++) a_byte(t1[i], i == 7);
    ma[0] = 32'h00000513; ma[1] = 32'h00100093; la = 2;
    check_val("A.loaded",     128'(ifa.loaded_words), 128'd2);
    check_val("A.mem_ready",  128'(ifa.mem_ready),    128'd1);
    check_val("A.load_ready", 128'(ifa.load_ready),   128'd0);
    a_byte(8'hFF, 1'b1);
    check_val("A.run_ignores_load", 128'(ifa.loaded_words), 128'd2);
    a_fetch(32'h0);
    a_fetch(32'h2);
    a_fetch(32'h3FC);
    a_fetch(32'h4);
    @(posedge clk); #1;

    // Backpressure with a queued request, then release with no bubble
    ifa.fetch_rsp_ready = 1'b0;
    a_fetch(32'h4);
    hold_e = exp_a(32'h4);
    ifa.fetch_req_valid = 1'b1; ifa.fetch_pc = 10'h0;
    repeat (3) begin
      @(posedge clk); #1;
      check_val("A.hold_valid",     128'(ifa.fetch_rsp_valid), 128'd1);
      check_val("A.hold_instr",     128'(ifa.fetch_rsp_instr), hold_e.instr);
      check_val("A.hold_mask",      128'(ifa.fetch_rsp_mask),  128'(hold_e.mask));
      check_val("A.hold_pc",        128'(ifa.fetch_rsp_pc),    128'(hold_e.pc));
      check_val("A.hold_req_ready", 128'(ifa.fetch_req_ready), 128'd0);
    end
    ifa.fetch_rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_val("A.nobubble_valid", 128'(ifa.fetch_rsp_valid), 128'd1);
    check_val("A.nobubble_pc",    128'(ifa.fetch_rsp_pc),    128'd0);
    ifa.fetch_req_valid = 1'b0;
    @(posedge clk); #1;

    // Flush against a held response and a fresh request
    ifa.fetch_rsp_ready = 1'b0;
    a_fetch(32'h0);
    ifa.fetch_req_valid = 1'b1; ifa.fetch_pc = 10'h4; ifa.flush = 1'b1; ifa.fetch_rsp_ready = 1'b1;
    @(negedge clk);
    check_val("A.flush_blocks_req", 128'(ifa.fetch_req_ready), 128'd0);
    @(posedge clk); #1;
    ifa.flush = 1'b0;
    check_val("A.flush_clears_valid", 128'(ifa.fetch_rsp_valid), 128'd0);
    @(posedge clk); #1;
    check_val("A.reissue_valid", 128'(ifa.fetch_rsp_valid), 128'd1);
    check_val("A.reissue_pc",    128'(ifa.fetch_rsp_pc),    128'd4);
    ifa.fetch_req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("A.sb_drained", 128'(qa.size()), 128'd0);

    // Big-endian partial final word
    b_reset();
    for (int i = 0; i < 7; i++) b_byte(t2[i], i == 6);
    mb[0] = 32'h00000513; mb[1] = 32'h00100000; lb = 2;
    check_val("B.loaded",    128'(ifb.loaded_words), 128'd2);
    check_val("B.mem_ready", 128'(ifb.mem_ready),    128'd1);
    b_fetch(32'h0);
    @(posedge clk); #1;

    // Four slots over three loaded words
    b_reset();
    for (int i = 0; i < 12; i++) b_byte(t3[i], i == 11);
    mb[0] = 32'h11223344; mb[1] = 32'h55667788; mb[2] = 32'h99AABBCC; lb = 3;
    check_val("B.loaded3", 128'(ifb.loaded_words), 128'd3);
    b_fetch(32'h4);
    b_fetch(32'h6);
    b_fetch(32'h0);
    @(posedge clk); #1;

    // Full-depth stream without load_last auto-completes
    b_reset();
    for (int i = 0; i < 15; i++) b_byte(8'(8'hA0 + i), 1'b0);
    check_val("B.pre_full_loaded",    128'(ifb.loaded_words), 128'd3);
    check_val("B.pre_full_mem_ready", 128'(ifb.mem_ready),    128'd0);
    b_byte(8'hAF, 1'b0);
    for (int j = 0; j < 4; j++)
      mb[j] = {8'(8'hA0 + 4*j), 8'(8'hA1 + 4*j), 8'(8'hA2 + 4*j), 8'(8'hA3 + 4*j)};
    lb = 4;
    check_val("B.full_loaded",     128'(ifb.loaded_words), 128'd4);
    check_val("B.full_mem_ready",  128'(ifb.mem_ready),    128'd1);
    check_val("B.full_load_ready", 128'(ifb.load_ready),   128'd0);
    b_byte(8'h55, 1'b0);
    check_val("B.byte17_ignored", 128'(ifb.loaded_words), 128'd4);
    b_fetch(32'h0);
    b_fetch(32'h8);
    b_fetch(32'hC);
    @(posedge clk); #1;

    // Reset in the middle of a load
    b_reset();
    for (int i = 0; i < 6; i++) b_byte(8'(8'h30 + i), 1'b0);
    check_val("B.mid_loaded", 128'(ifb.loaded_words), 128'd1);
    rst_nb = 1'b0;
    ifb.fetch_req_valid = 1'b1;
    @(posedge clk); #1;
    check_val("B.abort_loaded",    128'(ifb.loaded_words),    128'd0);
    check_val("B.abort_ready",     128'(ifb.load_ready),      128'd1);
    check_val("B.abort_req_ready", 128'(ifb.fetch_req_ready), 128'd0);
    ifb.fetch_req_valid = 1'b0;
    rst_nb = 1'b1; qb.delete();
    b_byte(8'hDE, 1'b0); b_byte(8'hAD, 1'b0); b_byte(8'hBE, 1'b0); b_byte(8'hEF, 1'b1);
    mb[0] = 32'hDEADBEEF; lb = 1;
    b_fetch(32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("B.sb_drained", 128'(qb.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader_fetch.md
Name: instr_mem_loader_fetch

Overview:
Parametrised instruction memory for the out-of-order core. It replaces the flat instruction bus into cpu_top with two ports. A byte-serial load port fills memory after reset, assembling words with selectable endianness. A multi-slot fetch port returns FETCH_WIDTH consecutive instructions per request, with valid/ready handshakes and a flush input. It sits between the bench (or a boot loader) and the fetch stage.

Parameters:
DEPTH_WORDS, 256, number of 32-bit instruction words; power of two, at least 4
FETCH_WIDTH, 2, instructions returned per fetch; legal range 1-4
LITTLE_ENDIAN, 1, 1 puts load byte k of a word at bits [8k+7:8k]; 0 puts byte 0 at bits [31:24]
PC_W, $clog2(DEPTH_WORDS*4), byte-address width (derived)
CNT_W, $clog2(DEPTH_WORDS+1), loaded-word count width (derived)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous, active-low reset
load_valid  in  1  load byte present
load_ready  out  1  high while state is LOAD
load_byte  in  8  next byte in address order
load_last  in  1  qualifies final byte of image
loaded_words  out  CNT_W  number of complete or padded words written
mem_ready  out  1  high while state is RUN
fetch_req_valid  in  1  fetch request
fetch_req_ready  out  1  request accepted this cycle when valid is also high
fetch_pc  in  PC_W  byte address of first slot
flush  in  1  drop the pending response; block new acceptance this cycle
fetch_rsp_valid  out  1  response held until ready
fetch_rsp_ready  in  1  consumer accepts response
fetch_rsp_instr  out  32*FETCH_WIDTH  slot i at bits [32i+31:32i]
fetch_rsp_mask  out  FETCH_WIDTH  slot i holds a loaded instruction
fetch_rsp_err  out  1  misaligned fetch_pc
fetch_rsp_pc  out  PC_W  echo of the accepted fetch_pc

Behaviour:
- Reset (reset_n low at a rising edge):
  - state=LOAD, byte_cnt=0, word shift register=0, loaded_words=0.
  - fetch_rsp_valid/instr/mask/err/pc all =0.
  - Memory array is not cleared. Stale contents are unreachable because slot validity uses loaded_words.
  - Reset mid-load or mid-fetch aborts the operation and returns the block to LOAD.
- States: LOAD -> RUN only. RUN is left only via reset.
- LOAD state, byte handshake: a byte is taken when load_valid && load_ready. The byte goes into lane byte_cnt[1:0] of the assembly register, mapped per LITTLE_ENDIAN.
- Word write: on the 4th byte (lane 3), the assembled word is written to mem[byte_cnt>>2] on that same edge, and loaded_words increments by 1.
- load_last on a taken byte:
  - A partial word is written with unfilled lanes = 0x00, and loaded_words increments.
  - State moves to RUN on the same edge.
- Auto-complete: taking byte DEPTH_WORDS*4-1 writes the final word and moves to RUN, whether or not load_last is set. byte_cnt never wraps.
- load_ready=(state==LOAD), combinational. Its value in the first cycle after reset is 1.
- load_valid in RUN is ignored.
- fetch_req_ready = (state==RUN) && !flush && (!fetch_rsp_valid || fetch_rsp_ready).
- Request acceptance (fetch_req_valid && fetch_req_ready): the response register loads on the next edge, giving one-cycle latency.
  - Per slot i: w = fetch_pc[PC_W-1:2]+i, with no wrap. mask[i] = (w < loaded_words) && (w < DEPTH_WORDS). instr slot = mem[w] if mask[i], else 0.
  - If fetch_pc[1:0]!=0: err=1, mask=0, instr=0.
- Response hold: fetch_rsp_valid stays high until fetch_rsp_ready. All response fields must stay stable while valid && !ready.
- Back-to-back: accept and ready in the same cycle gives one response per cycle, with no bubble.
- flush high:
  - fetch_rsp_valid clears on the next edge.
  - No request is accepted that cycle.
  - flush has priority over a simultaneous fetch_rsp_ready.
- Memory read is synchronous, so it maps to block RAM. Use FETCH_WIDTH read ports, or replicated arrays.

Decomposition:
- Package imem_pkg:
  - INSTR_W=32, BYTES_PER_WORD=4.
  - typedef enum logic {LOAD, RUN} imem_state_t.
  - fetch_rsp_t struct (valid, instr, mask, err, pc).
- Sub-module imem_byte_packer: byte counter, lane steering, endianness mapping and zero-padding. It outputs a word-write strobe, address and data.
- The top level holds the FSM, memory array and fetch response register.

Test Plan:
1. Defaults. Load bytes 13,05,00,00, 93,00,10,00 with load_last on the final byte -> loaded_words=2 and mem_ready=1. fetch_pc=0 -> next cycle rsp_valid=1, instr={0x00100093,0x00000513}, mask=2'b11, err=0.
2. LITTLE_ENDIAN=0. Load 00,00,05,13 then 00,10,00 with load_last -> word0=0x00000513, word1=0x00100000 (zero-padded), loaded_words=2.
3. FETCH_WIDTH=4, 3 words loaded. fetch_pc=0x4 -> mask=4'b0011, slots 2-3 = 0. fetch_pc=0x6 -> err=1, mask=0.
4. Backpressure. fetch_rsp_ready=0 for 3 cycles after a response -> response fields stable and fetch_req_ready=0. Ready then returns high with a new request valid -> next response follows on the next cycle, with no bubble.
5. flush asserted in the same cycle as a held response and a new request -> rsp_valid=0 next cycle and the request is not accepted. The request is re-presented after flush and is served normally.
6. Load without load_last:
   - DEPTH_WORDS=4: stream 16 bytes -> auto-transition to RUN and loaded_words=4; a 17th byte is not taken.
   - reset_n low mid-load after 6 bytes -> loaded_words=0, load_ready=1, fetch_req_ready=0.
